// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcodes, ALU commands, halt-FSM states and the
// ID/EX control bundle layout.
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_PADDSB = 4'd1;
   localparam logic [3:0] OP_SUB    = 4'd2;
   localparam logic [3:0] OP_NAND   = 4'd3;
   localparam logic [3:0] OP_XOR    = 4'd4;
   localparam logic [3:0] OP_SLL    = 4'd5;
   localparam logic [3:0] OP_SRL    = 4'd6;
   localparam logic [3:0] OP_SRA    = 4'd7;
   localparam logic [3:0] OP_LW     = 4'd8;
   localparam logic [3:0] OP_SW     = 4'd9;
   localparam logic [3:0] OP_LHB    = 4'd10;
   localparam logic [3:0] OP_LLB    = 4'd11;
   localparam logic [3:0] OP_B      = 4'd12;
   localparam logic [3:0] OP_CALL   = 4'd13;
   localparam logic [3:0] OP_RET    = 4'd14;
   localparam logic [3:0] OP_HLT    = 4'd15;

   localparam logic [3:0] ALU_ADD    = 4'b0000;
   localparam logic [3:0] ALU_SUB    = 4'b0001;
   localparam logic [3:0] ALU_PADDSB = 4'b0010;
   localparam logic [3:0] ALU_XOR    = 4'b0100;
   localparam logic [3:0] ALU_NAND   = 4'b1000;
   localparam logic [3:0] ALU_SLL    = 4'b1100;
   localparam logic [3:0] ALU_SRL    = 4'b1110;
   localparam logic [3:0] ALU_SRA    = 4'b1111;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } halt_state_e;

   typedef struct packed {
      logic [3:0] alu_cmd;
      logic       alu_src;
      logic       reg_wrt;
      logic       mem_to_reg;
      logic       mem_wrt;
      logic       branch;
      logic       call;
      logic       ret;
      logic       llb;
      logic       lhb;
      logic       set_over;
      logic       set_zero;
   } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode_pipe_if.sv
// IF/ID -> ID/EX control-stage bus: instruction/hazard inputs and the
// registered control bundle plus halt status.
interface ctrl_decode_pipe_if #(
   parameter int OPC_W     = 4,
   parameter int ALU_CMD_W = 4
);
   logic                 in_valid;
   logic [OPC_W-1:0]     opcode;
   logic                 stall;
   logic                 flush;
   logic                 out_valid;
   logic [ALU_CMD_W-1:0] alu_cmd;
   logic                 alu_src;
   logic                 reg_wrt;
   logic                 mem_to_reg;
   logic                 mem_wrt;
   logic                 branch;
   logic                 call;
   logic                 ret;
   logic                 llb;
   logic                 lhb;
   logic                 set_over;
   logic                 set_zero;
   logic                 fetch_stop;
   logic                 halted;
   logic                 illegal;

   modport master (
      output in_valid, opcode, stall, flush,
      input  out_valid, alu_cmd, alu_src, reg_wrt, mem_to_reg, mem_wrt,
             branch, call, ret, llb, lhb, set_over, set_zero,
             fetch_stop, halted, illegal
   );

   modport slave (
      input  in_valid, opcode, stall, flush,
      output out_valid, alu_cmd, alu_src, reg_wrt, mem_to_reg, mem_wrt,
             branch, call, ret, llb, lhb, set_over, set_zero,
             fetch_stop, halted, illegal
   );
endinterface

// File: rtl/ctrl_decode_comb.sv
// Pure combinational opcode decoder: control bundle, illegal flag and HLT
// detect. Illegal opcodes decode to an all-zero bundle.
module ctrl_decode_comb
   import wisc_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic [OPC_W-1:0] opcode_i,
   output ctrl_bundle_t     bundle_o,
   output logic             illegal_o,
   output logic             is_hlt_o
);

   logic       hi_bad;
   logic [3:0] opc_lo;

   assign opc_lo = opcode_i[3:0];

   if (OPC_W > 4) begin : g_wide
      assign hi_bad = |opcode_i[OPC_W-1:4];
   end else begin : g_narrow
      assign hi_bad = 1'b0;
   end

   assign illegal_o = hi_bad;
   assign is_hlt_o  = !hi_bad && (opc_lo == OP_HLT);

   always_comb begin
      bundle_o = '0;
      if (!hi_bad) begin
         case (opc_lo)
            OP_ADD:    begin bundle_o.alu_cmd = ALU_ADD;    bundle_o.reg_wrt = 1'b1;
                             bundle_o.set_over = 1'b1;      bundle_o.set_zero = 1'b1; end
            OP_PADDSB: begin bundle_o.alu_cmd = ALU_PADDSB; bundle_o.reg_wrt = 1'b1; end
            OP_SUB:    begin bundle_o.alu_cmd = ALU_SUB;    bundle_o.reg_wrt = 1'b1;
                             bundle_o.set_over = 1'b1;      bundle_o.set_zero = 1'b1; end
            OP_NAND:   begin bundle_o.alu_cmd = ALU_NAND;   bundle_o.reg_wrt = 1'b1;
                             bundle_o.set_zero = 1'b1; end
            OP_XOR:    begin bundle_o.alu_cmd = ALU_XOR;    bundle_o.reg_wrt = 1'b1;
                             bundle_o.set_zero = 1'b1; end
            OP_SLL:    begin bundle_o.alu_cmd = ALU_SLL;    bundle_o.reg_wrt = 1'b1;
                             bundle_o.set_zero = 1'b1;      bundle_o.alu_src = 1'b1; end
            OP_SRL:    begin bundle_o.alu_cmd = ALU_SRL;    bundle_o.reg_wrt = 1'b1;
                             bundle_o.set_zero = 1'b1;      bundle_o.alu_src = 1'b1; end
            OP_SRA:    begin bundle_o.alu_cmd = ALU_SRA;    bundle_o.reg_wrt = 1'b1;
                             bundle_o.set_zero = 1'b1;      bundle_o.alu_src = 1'b1; end
            OP_LW:     begin bundle_o.reg_wrt = 1'b1; bundle_o.mem_to_reg = 1'b1;
                             bundle_o.alu_src = 1'b1; end
            OP_SW:     begin bundle_o.mem_wrt = 1'b1; bundle_o.mem_to_reg = 1'b1;
                             bundle_o.alu_src = 1'b1; end
            OP_LHB:    begin bundle_o.reg_wrt = 1'b1; bundle_o.alu_src = 1'b1;
                             bundle_o.lhb = 1'b1; end
            OP_LLB:    begin bundle_o.reg_wrt = 1'b1; bundle_o.alu_src = 1'b1;
                             bundle_o.llb = 1'b1; end
            OP_B:      begin bundle_o.branch = 1'b1;  bundle_o.mem_to_reg = 1'b1; end
            OP_CALL:   begin bundle_o.reg_wrt = 1'b1; bundle_o.call = 1'b1; end
            OP_RET:    begin bundle_o.ret = 1'b1;     bundle_o.mem_to_reg = 1'b1; end
            OP_HLT:    begin bundle_o.mem_to_reg = 1'b1; end
         endcase
      end
   end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Registered ID-stage control: decode -> ID/EX bundle with flush/stall/accept
// priority, sticky illegal flag and the RUN/DRAIN/HALTED halt-drain FSM.
module ctrl_decode_pipe
   import wisc_pkg::*;
#(
   parameter int OPC_W     = 4,
   parameter int ALU_CMD_W = 4,
   parameter int DRAIN_CYC = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   ctrl_decode_pipe_if.slave bus
);

   localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   ctrl_bundle_t dec_bundle;
   logic         dec_illegal;
   logic         dec_hlt;
   logic         accept;

   halt_state_e  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ctrl_bundle_t bundle_q, bundle_d;
   logic         valid_q, valid_d;
   logic         illegal_q, illegal_d;
   logic         fetch_stop_q, fetch_stop_d;
   logic         halted_q, halted_d;

   ctrl_decode_comb #(
      .OPC_W (OPC_W)
   ) u_dec (
      .opcode_i  (bus.opcode),
      .bundle_o  (dec_bundle),
      .illegal_o (dec_illegal),
      .is_hlt_o  (dec_hlt)
   );

   assign accept = bus.in_valid && !bus.stall && !bus.flush && (state_q == ST_RUN);

   always_comb begin
      bundle_d  = bundle_q;
      valid_d   = valid_q;
      state_d   = state_q;
      cnt_d     = cnt_q;
      illegal_d = illegal_q | (accept & dec_illegal);

      if (bus.flush) begin
         bundle_d = '0;
         valid_d  = 1'b0;
      end else if (!bus.stall) begin
         if (accept && !dec_illegal) begin
            bundle_d = dec_bundle;
            valid_d  = 1'b1;
         end else begin
            bundle_d = '0;
            valid_d  = 1'b0;
         end
      end

      // A flush in DRAIN means an older branch cancelled the halt.
      case (state_q)
         ST_RUN: begin
            if (accept && dec_hlt) begin
               state_d = ST_DRAIN;
               cnt_d   = CNT_W'(DRAIN_CYC - 1);
            end
         end
         ST_DRAIN: begin
            if (bus.flush) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else if (!bus.stall) begin
               if (cnt_q == '0) state_d = ST_HALTED;
               else             cnt_d   = cnt_q - 1'b1;
            end
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_RUN;
      endcase

      fetch_stop_d = (state_d != ST_RUN);
      halted_d     = (state_d == ST_HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_RUN;
         cnt_q        <= '0;
         bundle_q     <= '0;
         valid_q      <= 1'b0;
         illegal_q    <= 1'b0;
         fetch_stop_q <= 1'b0;
         halted_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bundle_q     <= bundle_d;
         valid_q      <= valid_d;
         illegal_q    <= illegal_d;
         fetch_stop_q <= fetch_stop_d;
         halted_q     <= halted_d;
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.alu_cmd    = ALU_CMD_W'(bundle_q.alu_cmd);
   assign bus.alu_src    = bundle_q.alu_src;
   assign bus.reg_wrt    = bundle_q.reg_wrt;
   assign bus.mem_to_reg = bundle_q.mem_to_reg;
   assign bus.mem_wrt    = bundle_q.mem_wrt;
   assign bus.branch     = bundle_q.branch;
   assign bus.call       = bundle_q.call;
   assign bus.ret        = bundle_q.ret;
   assign bus.llb        = bundle_q.llb;
   assign bus.lhb        = bundle_q.lhb;
   assign bus.set_over   = bundle_q.set_over;
   assign bus.set_zero   = bundle_q.set_zero;
   assign bus.fetch_stop = fetch_stop_q;
   assign bus.halted     = halted_q;
   assign bus.illegal    = illegal_q;

endmodule
